// File: rtl/alu_pkg.sv
// Shared ALU control-word definitions: field layout, NOP word, opcode decode table
// and the sequencer FSM state type.
package alu_pkg;

   localparam int ALU_CTRL_W = 13;
   localparam int OP_IDX_W   = 4;

   localparam int PRI_REG_LSB  = 10;
   localparam int SEC_REG_LSB  = 8;
   localparam int BCNT_REG_LSB = 6;
   localparam int CMP_REG_BIT  = 5;
   localparam int CMP_DMX_BIT  = 4;
   localparam int PASS_DMX_BIT = 3;
   localparam int OUT_DMX_LSB  = 1;
   localparam int IN_DMX_BIT   = 0;

   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_NOP = '0;

   localparam logic [ALU_CTRL_W-1:0] DECODE_TABLE [16] = '{
      13'h1C00, 13'h1800, 13'h080A, 13'h0450,
      13'h0300, 13'h0200, 13'h0100, 13'h1C05,
      13'h1C07, 13'h0080, 13'h0020, 13'h0002,
      13'h000A, 13'h0010, 13'h0000, 13'h000A
   };

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } seq_state_e;

   function automatic logic [ALU_CTRL_W-1:0] decode_opcode(input logic [OP_IDX_W-1:0] op);
      return DECODE_TABLE[op];
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear that beats push/pop.
module instr_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok, pop_ok;

   assign full_o     = (count == CNT_W'(DEPTH));
   assign empty_o    = (count == '0);
   assign count_o    = count;
   assign pop_data_o = mem[rd_ptr];
   assign push_ok    = push_i && !full_o && !clear_i;
   assign pop_ok     = pop_i && !empty_o && !clear_i;

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= push_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_instruction_sequencer.sv
// Buffers {repeat, opcode} instructions and issues each decoded ALU control word
// for repeat+1 live cycles, with hold masking and synchronous flush.
module alu_instruction_sequencer
   import alu_pkg::*;
#(
   parameter int OPCODE_W   = 4,
   parameter int REPEAT_W   = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            instr_valid_i,
   output logic                            instr_ready_o,
   input  logic [OPCODE_W-1:0]             instr_opcode_i,
   input  logic [REPEAT_W-1:0]             instr_repeat_i,
   input  logic                            hold_i,
   input  logic                            flush_i,
   output logic [2:0]                      primary_register_control_o,
   output logic [1:0]                      secondary_register_control_o,
   output logic [1:0]                      bit_counter_register_control_o,
   output logic                            comparator_register_control_o,
   output logic                            comparator_demux_control_o,
   output logic                            passthrough_demux_control_o,
   output logic [1:0]                      output_demux_control_o,
   output logic                            input_demux_control_o,
   output logic                            issue_valid_o,
   output logic                            issue_last_o,
   output logic                            busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
   output logic                            dbg_state_o
);

   // Handshake: an instruction transfers on a rising edge where instr_valid_i and
   // instr_ready_o are both high; ready is low while full or flushing.
   localparam int ENTRY_W = REPEAT_W + OP_IDX_W;

   seq_state_e            state_q, state_d;
   logic [REPEAT_W-1:0]   cnt_q, cnt_d;
   logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_word;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop, live;
   logic [ENTRY_W-1:0]    fifo_rd_data;

   assign instr_ready_o = !fifo_full && !flush_i;
   assign fifo_push     = instr_valid_i && instr_ready_o;

   instr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (flush_i),
      .push_i      (fifo_push),
      .push_data_i ({instr_repeat_i, instr_opcode_i[OP_IDX_W-1:0]}),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_rd_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count_o)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ctrl_q  <= ALU_CTRL_NOP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ctrl_d   = ctrl_q;
      fifo_pop = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!hold_i && !fifo_empty) fifo_pop = 1'b1;
         end
         S_ISSUE: begin
            if (!hold_i) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - REPEAT_W'(1);
               end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  ctrl_d  = ALU_CTRL_NOP;
               end
            end
         end
      endcase
      // A pop loads the next instruction directly, so back-to-back issue has no bubble.
      if (fifo_pop) begin
         state_d = S_ISSUE;
         cnt_d   = fifo_rd_data[ENTRY_W-1:OP_IDX_W];
         ctrl_d  = decode_opcode(fifo_rd_data[OP_IDX_W-1:0]);
      end
      if (flush_i) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         ctrl_d   = ALU_CTRL_NOP;
         fifo_pop = 1'b0;
      end
   end

   assign live          = (state_q == S_ISSUE) && !hold_i && !flush_i;
   assign ctrl_word     = live ? ctrl_q : ALU_CTRL_NOP;
   assign issue_valid_o = live;
   assign issue_last_o  = live && (cnt_q == '0);
   assign busy_o        = (state_q == S_ISSUE) || !fifo_empty;
   assign dbg_state_o   = state_q;

   assign primary_register_control_o     = ctrl_word[PRI_REG_LSB  +: 3];
   assign secondary_register_control_o   = ctrl_word[SEC_REG_LSB  +: 2];
   assign bit_counter_register_control_o = ctrl_word[BCNT_REG_LSB +: 2];
   assign comparator_register_control_o  = ctrl_word[CMP_REG_BIT];
   assign comparator_demux_control_o     = ctrl_word[CMP_DMX_BIT];
   assign passthrough_demux_control_o    = ctrl_word[PASS_DMX_BIT];
   assign output_demux_control_o         = ctrl_word[OUT_DMX_LSB  +: 2];
   assign input_demux_control_o          = ctrl_word[IN_DMX_BIT];

endmodule

// File: doc/alu_instruction_sequencer.md
# alu_instruction_sequencer

Parametrised successor to the ALU opcode decoder. It accepts a stream of `{repeat, opcode}` instructions over a valid/ready handshake and buffers them in a small FIFO. Each instruction is decoded into the 13-bit ALU control word and that word is issued for `repeat+1` consecutive cycles, with stall (`hold_i`) and `flush_i` support. It sits between the host command interface and the ALU datapath register/demux controls.

## Interface
- `OPCODE_W`, 4: opcode width; only values 0x0–0xF are decoded, wider opcodes use their low 4 bits.
- `REPEAT_W`, 6: repeat-count width; an instruction issues 1..2^REPEAT_W cycles.
- `FIFO_DEPTH`, 4: instruction buffer depth; power of two, ≥2.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `instr_valid_i`  in  1  instruction offered.
- `instr_ready_o`  out  1  `!full && !flush_i`; transfer when valid && ready.
- `instr_opcode_i`  in  OPCODE_W  opcode.
- `instr_repeat_i`  in  REPEAT_W  extra issue cycles (0 = issue once).
- `hold_i`  in  1  datapath stall; freezes issue.
- `flush_i`  in  1  synchronous flush of FIFO and current instruction.
- `primary_register_control_o`  out  3  ctrl[12:10].
- `secondary_register_control_o`  out  2  ctrl[9:8].
- `bit_counter_register_control_o`  out  2  ctrl[7:6].
- `comparator_register_control_o`  out  1  ctrl[5].
- `comparator_demux_control_o`  out  1  ctrl[4].
- `passthrough_demux_control_o`  out  1  ctrl[3].
- `output_demux_control_o`  out  2  ctrl[2:1].
- `input_demux_control_o`  out  1  ctrl[0].
- `issue_valid_o`  out  1  control word is a live issue this cycle.
- `issue_last_o`  out  1  final issue cycle of the current instruction.
- `busy_o`  out  1  in ISSUE state or FIFO non-empty.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH+1)  buffered instructions.

## Operation
- **Decode table (13-bit ctrl, hex):**
  - 0:1C00, 1:1800, 2:080A, 3:0450, 4:0300, 5:0200, 6:0100, 7:1C05
  - 8:1C07, 9:0080, A:0020, B:0002, C:000A, D:0010, E:0000, F:000A
- **NOP word:** 0x0000, driven whenever not issuing.
- **FSM states:**
  - IDLE: outputs NOP, `issue_valid_o`=0. If FIFO non-empty and !hold_i, pop, load ctrl register and down-counter = repeat, go to ISSUE.
  - ISSUE: ctrl register drives outputs, `issue_valid_o`=1.
    - hold_i=1: outputs forced to NOP, `issue_valid_o`=0, counter frozen, no pop.
    - hold_i=0 and counter≠0: decrement.
    - hold_i=0 and counter=0 (`issue_last_o`=1): if FIFO non-empty, pop next instruction at the same edge (no bubble); else go to IDLE.
- **hold_i** is sampled combinationally onto the outputs (masking) and registered for state effects.
- **flush_i:**
  - At the next edge: FIFO empties, FSM goes to IDLE, counter clears.
  - During the flush cycle the outputs are NOP and `issue_valid_o`=0.
  - A push offered in the same cycle is refused (ready=0).
- **Full FIFO:** ready=0 even if a pop occurs in the same cycle.
- **Push and pop on a non-full FIFO in the same cycle:** both happen; the count is unchanged.

## Timing
- **Reset values:**
  - FIFO empty, `fifo_count_o`=0, FSM in IDLE, counter 0.
  - All control outputs 0, `issue_valid_o`/`issue_last_o`/`busy_o`=0.
  - `instr_ready_o`=1 (when flush_i=0).
- **Latency:** an instruction accepted at edge t into an empty, idle sequencer appears on the outputs after edge t+1.
- **Throughput:** back-to-back instructions with repeat=0 issue one per cycle.
- **Hold cycles** stretch the issue: the total live cycles per instruction stay at repeat+1.
- **Reset asserted mid-issue:** all state and outputs clear immediately; no partial instruction resumes after reset release.

## Structure
- **Package `alu_pkg`:** control field widths and bit offsets, `ALU_CTRL_W`=13, `ALU_CTRL_NOP`, the 16-entry decode constant array, and a `decode_opcode` function.
- **Sub-module `instr_fifo`:** parametrised width/depth synchronous FIFO with count, full/empty, async active-high reset, and synchronous clear (used by flush).
- **Top level:** FSM, repeat counter, ctrl register, output masking and field slicing.

## Test plan
- **Reset then single op:** reset, push opcode 0x8 repeat 0 → exactly 1 cycle of ctrl 0x1C07 with issue_valid=1 and issue_last=1, at edge t+1; then NOP, busy=0.
- **Repeat:** push 0x3 repeat 5 → 6 consecutive cycles of ctrl 0x0450; issue_last on the 6th only.
- **Hold:** push 0x2 repeat 2, assert hold on the 2nd issue cycle for 3 cycles → outputs NOP during hold; total of 3 live 0x080A cycles.
- **Back-to-back and full:** push 0x0, 0x4, 0x7, 0x9 (repeat 0) while ready → ready drops when 4 are buffered; ctrl issues 1C00, 0300, 1C05, 0080 on consecutive cycles with no bubble.
- **Flush:** flush mid-issue of 0xA repeat 10 with 2 instructions queued and a simultaneous push → next cycle NOP, fifo_count=0, pushed instruction never issues.
- **Async reset mid-issue:** pulse rst_i between edges during a repeat → outputs 0 immediately; after release the sequencer is idle.
